// File: rtl/nt_subckt_bist_driver_if.sv
// Stimulus/response bundle between the BIST driver (master) and the harness/subcircuit side (slave).
interface nt_subckt_bist_driver_if;
    logic        start;
    logic        abort;
    logic        resp;
    logic        I4561;
    logic        I2678;
    logic        I1375;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic        pass;

    modport master (
        input  start, abort, resp,
        output I4561, I2678, I1375, busy, done, signature, pass
    );

    modport slave (
        output start, abort, resp,
        input  I4561, I2678, I1375, busy, done, signature, pass
    );
endinterface

// File: rtl/nt_subckt_bist_driver.sv
// BIST driver for the Nt-node subcircuits: LFSR stimulus, MISR compaction of the response.
// Optional golden compare enabled by defining NT_BIST_GOLDEN_CMP_EN.
module nt_subckt_bist_driver #(
    parameter int          PATTERNS = 1000,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          LAT      = 2,
    parameter logic [15:0] GOLDEN   = 16'h0000
) (
    input  logic                          I1470_clk,
    input  logic                          I1477_rst,
    nt_subckt_bist_driver_if.master       bus
);
    localparam int CW = $clog2(PATTERNS + 1);
    localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [CW-1:0] CNT_LAST = CW'(PATTERNS - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    state_e          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [15:0]     misr_q, misr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic [LAT-1:0]  vld_pipe_q, vld_pipe_d;
    logic [2:0]      stim_q, stim_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            shift;
    logic            vld_in;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] m, input logic r);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10] ^ r};
    endfunction

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        misr_d     = misr_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        vld_pipe_d = vld_pipe_q;
        shift      = 1'b0;
        vld_in     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    lfsr_d     = SEED_EFF;
                    misr_d     = '0;
                    cnt_d      = '0;
                    vld_pipe_d = '0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d    = IDLE;
                    vld_pipe_d = '0;
                end else begin
                    lfsr_d = lfsr_next(lfsr_q);
                    cnt_d  = cnt_q + CW'(1);
                    shift  = 1'b1;
                    vld_in = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FLUSH;
                        flush_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (bus.abort) begin
                    state_d    = IDLE;
                    vld_pipe_d = '0;
                end else begin
                    shift = 1'b1;
                    if (flush_q == FL_LAST) state_d = DONE;
                    else                    flush_d = flush_q + FW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The delay line lines up each capture with the response to its own vector.
        if (shift) begin
            vld_pipe_d[0] = vld_in;
            for (int i = 1; i < LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
            if (vld_pipe_q[LAT-1]) misr_d = misr_next(misr_q, bus.resp);
        end

        busy_d = (state_d == RUN) || (state_d == FLUSH);
        done_d = (state_d == DONE);
        stim_d = (state_d == RUN) ? lfsr_d[2:0] : 3'b000;
    end

`ifdef NT_BIST_GOLDEN_CMP_EN
    always_comb begin
        pass_d = pass_q;
        if (state_d != DONE)      pass_d = 1'b0;
        else if (state_q != DONE) pass_d = (misr_d == GOLDEN);
    end
`else
    logic unused_golden;
    assign unused_golden = ^GOLDEN;
    assign pass_d        = 1'b0;
`endif

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED_EFF;
            misr_q     <= '0;
            cnt_q      <= '0;
            flush_q    <= '0;
            vld_pipe_q <= '0;
            stim_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            misr_q     <= misr_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            vld_pipe_q <= vld_pipe_d;
            stim_q     <= stim_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign bus.I4561     = stim_q[0];
    assign bus.I2678     = stim_q[1];
    assign bus.I1375     = stim_q[2];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = misr_q;
    assign bus.pass      = pass_q;
endmodule
